// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode, flag bit positions, FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FLAG_NEGATIVE = 2'd0,
    FLAG_ZERO     = 2'd1,
    FLAG_CARRY    = 2'd2,
    FLAG_OVERFLOW = 2'd3
  } flag_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + (b ^ sub) + sub, with carry-out and signed overflow.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  // Invert b for subtraction and add the +1 through the carry-in.
  always_comb begin
    b_eff       = b ^ {WIDTH{sub}};
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    // Overflow: both addends share a sign and the sum's sign differs from it.
    ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with NZCV flags, valid/ready on both sides and a shift-add multiplier.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for in_valid; single-cycle ops resolve here
// ST_MUL  | busy=1, one multiplier bit consumed per cycle, WIDTH cycles
// ST_DONE | out_valid=1, result/flags held until out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  alu_op_e            op;
  logic               accept;
  logic               final_step;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;

  logic               as_sub;
  logic [WIDTH-1:0]   as_sum;
  logic               as_cout;
  logic               as_ovf;

  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flags;

  assign op         = alu_op_e'(alucontrol);
  assign accept     = in_valid && (state_q == ST_IDLE);
  assign final_step = (state_q == ST_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
  assign as_sub     = (op != OP_ADD);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (a),
    .b   (b),
    .sub (as_sub),
    .sum (as_sum),
    .cout(as_cout),
    .ovf (as_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (op == OP_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (final_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure state decodes or registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_MUL);
    out_valid = (state_q == ST_DONE);
    result    = result_q;
    flags     = flags_q;
  end

  // Single-cycle ops evaluated straight from the port operands on the accept cycle.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res                  = as_sum;
        alu_flags[FLAG_CARRY]    = as_cout;
        alu_flags[FLAG_OVERFLOW] = as_ovf;
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      // Signed less-than from a-b: sign of the true difference is sign ^ overflow.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, as_ovf ^ as_sum[WIDTH-1]};
      default: alu_res = '0;
    endcase
    alu_flags[FLAG_NEGATIVE] = alu_res[WIDTH-1];
    alu_flags[FLAG_ZERO]     = (alu_res == '0);
  end

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Multiplier operand, accumulator and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && op == OP_MUL) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == ST_MUL) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_nxt;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Result/flags registers; only written on entry to DONE so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept && op == OP_RSVD) begin
      result_q <= '0;
      flags_q  <= 4'b0010;
    end else if (accept && op != OP_MUL) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
    end else if (final_step) begin
      result_q <= acc_nxt[WIDTH-1:0];
      flags_q  <= {1'b0, |acc_nxt[2*WIDTH-1:WIDTH], ~|acc_nxt[WIDTH-1:0],
                   acc_nxt[WIDTH-1]};
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: 32-bit directed table + random, 4-bit exhaustive.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        sel4;
  logic [31:0] a_drv, b_drv;
  logic [2:0]  op_drv;
  logic        out_ready;

  logic        ir32, ov32, busy32;
  logic [31:0] res32;
  logic [3:0]  fl32;
  logic        ir4, ov4, busy4;
  logic [3:0]  res4;
  logic [3:0]  fl4;

  logic        iv32, iv4;
  logic        cur_ir, cur_ov, cur_busy;
  logic [31:0] cur_res;
  logic [3:0]  cur_fl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign iv32     = in_valid & ~sel4;
  assign iv4      = in_valid & sel4;
  assign cur_ir   = sel4 ? ir4 : ir32;
  assign cur_ov   = sel4 ? ov4 : ov32;
  assign cur_busy = sel4 ? busy4 : busy32;
  assign cur_res  = sel4 ? {28'd0, res4} : res32;
  assign cur_fl   = sel4 ? fl4 : fl32;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a_drv), .b(b_drv), .alucontrol(op_drv),
    .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .flags(fl32), .busy(busy32)
  );

  alu_mc #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .alucontrol(op_drv),
    .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .flags(fl4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: {flags, result} from plain wide integer arithmetic on w-bit operands.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] av,
                                        input logic [31:0] bv, input int w);
    logic [63:0] mask, ua, ub, full, r;
    longint sa, sb, s, smin, smax;
    logic c, v, n, z;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, av} & mask;
    ub = {32'd0, bv} & mask;
    sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    smin = -(longint'(1) << (w - 1));
    smax = (longint'(1) << (w - 1)) - 1;
    c = 1'b0; v = 1'b0; r = '0; full = '0;
    case (op)
      3'd0: begin full = ua + ub; r = full & mask; c = full[w];
                  s = sa + sb; v = (s < smin) || (s > smax); end
      3'd1: begin full = ua + ((~ub) & mask) + 64'd1; r = full & mask; c = full[w];
                  s = sa - sb; v = (s < smin) || (s > smax); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 64'd1 : 64'd0;
      3'd6: begin full = ua * ub; r = full & mask; c = ((full >> w) != 0); end
      default: r = '0;
    endcase
    n = r[w-1];
    z = (r == 0);
    return {v, c, z, n, r[31:0]};
  endfunction

  // Issue one op, track latency/busy/in_ready, hold out_ready low for `stall` cycles, complete.
  task automatic run_op(input bit w4, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er, input logic [3:0] ef,
                        input int stall, input string tag);
    int w, lat, busy_cnt, exp_lat;
    bit ir_bad, unstable;
    logic [31:0] r0;
    logic [3:0] f0;
    w = w4 ? 4 : 32;
    exp_lat = (op == 3'd6) ? w + 1 : 1;
    @(negedge clk);
    sel4 = w4;
    out_ready = 1'b0;
    in_valid = 1'b1; op_drv = op; a_drv = av; b_drv = bv;
    @(posedge clk);
    @(negedge clk);
    lat = 1; busy_cnt = 0; ir_bad = 0;
    while (!cur_ov && lat < 200) begin
      if (cur_ir) ir_bad = 1;
      if (cur_busy) busy_cnt++;
      in_valid = 1'($urandom); a_drv = $urandom; b_drv = $urandom; op_drv = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (cur_ir) ir_bad = 1;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, busy_cnt, (op == 3'd6) ? w : 0);
    chk({tag, " in_ready_low"}, ir_bad, 0);
    chk({tag, " result"}, cur_res, er);
    chk({tag, " flags"}, cur_fl, ef);
    r0 = cur_res; f0 = cur_fl; unstable = 0;
    repeat (stall) begin
      in_valid = 1'($urandom); a_drv = $urandom; b_drv = $urandom; op_drv = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (!cur_ov || cur_ir || cur_res !== r0 || cur_fl !== f0) unstable = 1;
    end
    chk({tag, " hold_stable"}, unstable, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " back_idle"}, {cur_ov, cur_ir}, 2'b01);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic [3:0]  fl;
    int          stall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [35:0] m;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; sel4 = 1'b0; out_ready = 1'b0;
    a_drv = '0; b_drv = '0; op_drv = '0;

    //            op    a             b             result        NZCV->{V,C,Z,N} stall
    vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 0});
    vecs.push_back('{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100, 1});
    vecs.push_back('{3'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 0});
    vecs.push_back('{3'd6, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0110, 2});
    vecs.push_back('{3'd4, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 4'b0000, 5});
    vecs.push_back('{3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 4'b0000, 0});
    vecs.push_back('{3'd3, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0010, 0});
    vecs.push_back('{3'd7, 32'h00001234, 32'h00005678, 32'h00000000, 4'b0010, 1});
    vecs.push_back('{3'd1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0001, 0});
    vecs.push_back('{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 0});
    vecs.push_back('{3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0100, 3});
    vecs.push_back('{3'd5, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0010, 0});
    vecs.push_back('{3'd6, 32'h00001234, 32'h00000010, 32'h00012340, 4'b0000, 0});

    #12;
    chk("reset in_ready32", ir32, 1);
    chk("reset out_valid32", ov32, 0);
    chk("reset busy32", busy32, 0);
    chk("reset result32", res32, 0);
    chk("reset flags32", fl32, 0);
    chk("reset in_ready4", ir4, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl,
             vecs[i].stall, $sformatf("vec%0d", i));

    // Reset asserted in the 10th MUL cycle must clear everything without a clock edge.
    @(negedge clk);
    sel4 = 1'b0;
    in_valid = 1'b1; op_drv = 3'd6; a_drv = 32'h00012345; b_drv = 32'h00000777;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("midmul busy_before", busy32, 1);
    rst_n = 1'b0;
    #1;
    chk("midmul rst in_ready", ir32, 1);
    chk("midmul rst out_valid", ov32, 0);
    chk("midmul rst busy", busy32, 0);
    chk("midmul rst result", res32, 0);
    chk("midmul rst flags", fl32, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 3'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1, "post_rst_add");

    // Random 32-bit traffic against the model.
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom);
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) rb = ra;
      m = model(rop, ra, rb, 32);
      run_op(1'b0, rop, ra, rb, m[31:0], m[35:32], $urandom_range(0, 3),
             $sformatf("rnd32_%0d", i));
    end

    // Exhaustive 4-bit sweep with random idle gaps and backpressure.
    for (int op = 0; op < 8; op++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          m = model(3'(op), 32'(x), 32'(y), 4);
          repeat ($urandom_range(0, 1)) @(negedge clk);
          run_op(1'b1, 3'(op), 32'(x), 32'(y), m[31:0], m[35:32], $urandom_range(0, 2),
                 $sformatf("w4 op%0d a%0h b%0h", op, x, y));
        end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
